spi_regbank: RTL and testbench

- Register bank directly downstream of the SPI slave.
- Consumes the slave's Data_Addr, data_fromPI and RAM_we, and returns Data_Read for the Pi read-back.
- Holds the Pi-writable command registers for the FPGA application.
- Atomically snapshots FPGA-side status words for reading.
- Provides a communication watchdog that forces a safe state when the Pi stops writing.

---
 rtl/spi_regbank.sv | 108 ++++++++++
 tb/tb_spi_regbank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_regbank.sv
// rtl/spi_regbank.sv - SPI-facing register bank: RW command regs, RO status snapshots, comms watchdog.
module spi_regbank #(
  parameter int          N_RW        = 16,
  parameter int          N_RO        = 16,
  parameter int          WDOG_CYCLES = 5000000,
  parameter logic [15:0] WDOG_MASK   = 16'h000F,
  parameter logic [31:0] BLOCK_ID    = 32'h454C4D45
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [7:0]          Data_Addr,
  input  logic [31:0]         data_fromPI,
  input  logic                RAM_we,
  output logic [31:0]         Data_Read,
  input  logic [32*N_RO-1:0]  ro_in,
  output logic [32*N_RW-1:0]  rw_out,
  output logic [N_RW-1:0]     wr_pulse,
  output logic                wdog_expired
);

  localparam int             CW      = $clog2(WDOG_CYCLES + 1);
  localparam logic [CW-1:0]  WD_MAX  = CW'(WDOG_CYCLES);
  localparam logic [CW-1:0]  WD_LAST = CW'(WDOG_CYCLES - 1);
  localparam logic [8:0]     RW_END  = 9'(N_RW);
  localparam logic [8:0]     RO_END  = 9'(16 + N_RO);

  // Both banks are sized to the full 16-entry address window; entries beyond
  // N_RW / N_RO are never written and stay at their reset value of zero.
  logic [31:0]   rw     [16];
  logic [31:0]   shadow [16];
  logic [31:0]   wr_cnt;
  logic [1:0]    err;
  logic [CW-1:0] wdog_cnt;
  logic          we_prev;

  logic accept, wr_rw, wr_err, wr_clr, snap, expire;
  logic in_rw, in_ro;

  assign in_rw  = {1'b0, Data_Addr} < RW_END;
  assign in_ro  = ({1'b0, Data_Addr} >= 9'h010) && ({1'b0, Data_Addr} < RO_END);
  assign accept = RAM_we & ~we_prev;
  assign wr_rw  = accept && in_rw;
  assign wr_err = accept && (((Data_Addr >= 8'h10) && (Data_Addr <= 8'h21)) || (Data_Addr >= 8'h24));
  assign wr_clr = accept && (Data_Addr == 8'h22);
  assign snap   = accept && (Data_Addr == 8'h23) && data_fromPI[0];
  // An RW write in the expiry cycle wins and suppresses the expiry entirely.
  assign expire = !wr_rw && (wdog_cnt == WD_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) begin
        rw[i]     <= '0;
        shadow[i] <= '0;
      end
      wr_cnt       <= '0;
      err          <= '0;
      wdog_cnt     <= '0;
      wdog_expired <= 1'b0;
      we_prev      <= 1'b0;
      wr_pulse     <= '0;
    end else begin
      we_prev  <= RAM_we;
      wr_pulse <= '0;
      if (accept) wr_cnt <= wr_cnt + 32'd1;
      for (int i = 0; i < N_RW; i++) begin
        if (wr_rw && (Data_Addr[3:0] == 4'(i))) begin
          rw[i]       <= data_fromPI;
          wr_pulse[i] <= 1'b1;
        end else if (expire && WDOG_MASK[i]) begin
          rw[i] <= '0;
        end
      end
      if (snap) begin
        for (int i = 0; i < N_RO; i++) shadow[i] <= ro_in[32*i +: 32];
      end
      // W1C: set sources are ORed in after the clear so set wins.
      err <= (err & ~(wr_clr ? data_fromPI[1:0] : 2'b00)) | {expire, wr_err};
      if (wr_rw) begin
        wdog_cnt     <= '0;
        wdog_expired <= 1'b0;
      end else begin
        if (wdog_cnt != WD_MAX) wdog_cnt <= wdog_cnt + 1'b1;
        if (expire) wdog_expired <= 1'b1;
      end
    end
  end

  always_comb begin
    Data_Read = '0;
    if (in_rw) begin
      Data_Read = rw[Data_Addr[3:0]];
    end else if (in_ro) begin
      Data_Read = shadow[Data_Addr[3:0]];
    end else begin
      case (Data_Addr)
        8'h20:   Data_Read = BLOCK_ID;
        8'h21:   Data_Read = wr_cnt;
        8'h22:   Data_Read = {30'd0, err};
        default: Data_Read = '0;
      endcase
    end
  end

  for (genvar g = 0; g < N_RW; g++) begin : g_out
    assign rw_out[32*g +: 32] = rw[g];
  end

endmodule

// File: tb/tb_spi_regbank.sv
// tb/tb_spi_regbank.sv - scoreboard bench for spi_regbank with directed vectors.
`timescale 1ns/1ps
module tb_spi_regbank;

  localparam int N_RW = 16;
  localparam int N_RO = 16;
  localparam int WD   = 100;

  logic               Clk = 1'b0;
  logic               Reset_n;
  logic [7:0]         Data_Addr;
  logic [31:0]        data_fromPI;
  logic               RAM_we;
  logic [31:0]        Data_Read;
  logic [32*N_RO-1:0] ro_in;
  logic [32*N_RW-1:0] rw_out;
  logic [N_RW-1:0]    wr_pulse;
  logic               wdog_expired;

  spi_regbank #(.N_RW(N_RW), .N_RO(N_RO), .WDOG_CYCLES(WD)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Data_Addr(Data_Addr), .data_fromPI(data_fromPI),
    .RAM_we(RAM_we), .Data_Read(Data_Read), .ro_in(ro_in), .rw_out(rw_out),
    .wr_pulse(wr_pulse), .wdog_expired(wdog_expired)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  event  chk_ev;
  int    checks = 0;
  int    errors = 0;
  int    p1_cnt = 0;
  logic [31:0] wcount;

  always @(negedge Clk) if (wr_pulse[1]) p1_cnt++;

  // kind: 0 Data_Read, 1 rw_out word, 2 wr_pulse, 3 wdog_expired, 4 wr_pulse[1] tally
  initial begin
    item_t it;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.kind)
          0:       act = Data_Read;
          1:       act = rw_out[32*it.idx +: 32];
          2:       act = 32'(wr_pulse);
          3:       act = {31'd0, wdog_expired};
          default: act = 32'(p1_cnt);
        endcase
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s got=%h exp=%h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int kind, input int idx, input logic [31:0] exp);
    item_t it;
    it.name = name; it.kind = kind; it.idx = idx; it.exp = exp;
    sb.push_back(it);
    -> chk_ev;
    #0.01;
  endtask

  task automatic chk_rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    Data_Addr = a;
    #0.01;
    expect_val(name, 0, 0, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge Clk);
    Data_Addr = a; data_fromPI = d; RAM_we = 1'b1;
    @(negedge Clk);
    RAM_we = 1'b0;
    wcount = wcount + 32'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int base;
    Reset_n = 1'b0; RAM_we = 1'b0; Data_Addr = '0; data_fromPI = '0; ro_in = '0; wcount = '0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    chk_rd("rst_rw0", 8'h00, 32'h0);
    chk_rd("rst_ro0", 8'h10, 32'h0);
    chk_rd("rst_cnt", 8'h21, 32'h0);
    chk_rd("rst_flags", 8'h22, 32'h0);
    chk_rd("block_id", 8'h20, 32'h454C4D45);
    expect_val("rst_wdog", 3, 0, 32'h0);
    expect_val("rst_pulse", 2, 0, 32'h0);

    wr(8'h03, 32'hCAFEF00D);
    expect_val("w3_word", 1, 3, 32'hCAFEF00D);
    expect_val("w3_pulse", 2, 0, 32'h0008);
    @(negedge Clk);
    expect_val("w3_pulse_off", 2, 0, 32'h0);
    chk_rd("w3_read", 8'h03, 32'hCAFEF00D);
    chk_rd("w3_cnt", 8'h21, 32'd1);

    base = p1_cnt;
    @(negedge Clk);
    Data_Addr = 8'h01; data_fromPI = 32'h1234; RAM_we = 1'b1;
    repeat (5) @(negedge Clk);
    RAM_we = 1'b0;
    wcount = wcount + 32'd1;
    @(negedge Clk);
    expect_val("hold_pulses", 4, 0, 32'(base + 1));
    chk_rd("hold_cnt", 8'h21, wcount);
    chk_rd("hold_read", 8'h01, 32'h1234);

    ro_in[32*2 +: 32] = 32'h11111111;
    wr(8'h23, 32'h1);
    ro_in[32*2 +: 32] = 32'h22222222;
    chk_rd("snap1", 8'h12, 32'h11111111);
    wr(8'h23, 32'h2);
    chk_rd("snap_bit0_only", 8'h12, 32'h11111111);
    wr(8'h23, 32'h1);
    chk_rd("snap2", 8'h12, 32'h22222222);
    chk_rd("cmd_reads0", 8'h23, 32'h0);
    chk_rd("snap_noerr", 8'h22, 32'h0);

    wr(8'h40, 32'h0);
    chk_rd("unmap_flag", 8'h22, 32'h1);
    chk_rd("unmap_cnt", 8'h21, wcount);
    wr(8'h22, 32'h1);
    chk_rd("w1c_clear", 8'h22, 32'h0);
    wr(8'h10, 32'h5);
    chk_rd("ro_wr_flag", 8'h22, 32'h1);
    chk_rd("ro_wr_nochange", 8'h10, 32'h0);
    wr(8'h22, 32'h1);
    chk_rd("unmap_read", 8'h24, 32'h0);

    wr(8'h02, 32'hDEAD);
    Reset_n = 1'b0;
    wcount = '0;
    #0.01;
    expect_val("rst_mid_pulse", 2, 0, 32'h0);
    expect_val("rst_mid_word", 1, 2, 32'h0);
    chk_rd("rst_mid_cnt", 8'h21, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    wr(8'h02, 32'hAA);
    wr(8'h04, 32'h44);
    wr(8'h00, 32'h5);
    wr(8'h05, 32'h7);
    repeat (WD - 1) @(negedge Clk);
    expect_val("wd_before", 3, 0, 32'h0);
    @(negedge Clk);
    expect_val("wd_expired", 3, 0, 32'h1);
    expect_val("wd_word0", 1, 0, 32'h0);
    expect_val("wd_word2", 1, 2, 32'h0);
    expect_val("wd_word4", 1, 4, 32'h44);
    expect_val("wd_word5", 1, 5, 32'h7);
    expect_val("wd_nopulse", 2, 0, 32'h0);
    chk_rd("wd_flags", 8'h22, 32'h2);
    wr(8'h00, 32'h9);
    expect_val("wd_release", 3, 0, 32'h0);
    expect_val("wd_word0_new", 1, 0, 32'h9);
    expect_val("wd_rel_pulse", 2, 0, 32'h1);

    wr(8'h22, 32'h2);
    chk_rd("wd_flag_cleared", 8'h22, 32'h0);
    wr(8'h00, 32'h1);
    repeat (WD - 2) @(negedge Clk);
    wr(8'h22, 32'h2);
    chk_rd("set_wins", 8'h22, 32'h2);
    expect_val("set_wins_wdog", 3, 0, 32'h1);

    wr(8'h00, 32'h1);
    repeat (WD - 2) @(negedge Clk);
    wr(8'h00, 32'hAB);
    expect_val("write_wins_wdog", 3, 0, 32'h0);
    expect_val("write_wins_word", 1, 0, 32'hAB);
    repeat (3) @(negedge Clk);
    expect_val("write_wins_later", 3, 0, 32'h0);
    chk_rd("final_cnt", 8'h21, wcount);

    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
